pc_stack_unit: RTL and testbench
================================

Name: pc_stack_unit

Overview:
- Parametrised program counter with relative increment, absolute jump, and a hardware return-address stack (RAS) for call/return.
- Sits in the fetch stage and drives the instruction-memory address.
- Control comes from the decoder; `stall` freezes fetch.
- Replaces the fixed 16-bit counter. Idle now holds PC instead of clearing it.

Parameters:
- PC_W, 16, program counter / address width in bits
- OFF_W, 8, width of signed relative offset `in`; must be <= PC_W
- RAS_DEPTH, 4, return-address stack entries; power of two, >= 2
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- stall  input  1  1 = hold all state this cycle
- inc  input  1  relative step: PC <= PC + sext(in)
- in  input  OFF_W  signed two's-complement offset for inc
- wEnb  input  1  absolute jump: PC <= din
- din  input  PC_W  jump / call target
- call  input  1  push PC+1, then PC <= din
- ret  input  1  pop top of RAS into PC
- PC  output  PC_W  current program counter (registered)
- ras_empty  output  1  RAS holds 0 entries
- ras_full  output  1  RAS holds RAS_DEPTH entries
- ras_ovf  output  1  sticky: call attempted while full
- ras_unf  output  1  sticky: ret attempted while empty

Behaviour:
- Reset (reset=0, async, immediate):
  - PC=RESET_PC, stack pointer=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0.
  - Stack contents are don't-care.
- All updates occur on posedge clk. Outputs are registered.
- Priority per cycle: stall > ret > call > wEnb > inc > hold. Only the highest-priority asserted request acts.
- stall: PC, pointer, stack and flags unchanged.
- hold (no request): PC unchanged. The PC never auto-clears.
- inc: PC <= PC + sign_extend(in, PC_W), modulo 2^PC_W.
  - Example: PC=0x0001, in=0xFE -> 0xFFFF.
- wEnb: PC <= din. RAS untouched.
- call:
  - Not full: stack[sp] <= PC+1 (mod 2^PC_W), sp <= sp+1, PC <= din.
  - Full: jump still taken, push discarded, sp unchanged, ras_ovf <= 1.
- ret:
  - Not empty: PC <= stack[sp-1], sp <= sp-1.
  - Empty: PC unchanged, ras_unf <= 1.
- Pointer has log2(RAS_DEPTH)+1 bits. ras_empty = (sp==0); ras_full = (sp==RAS_DEPTH). Both are combinational from the registered sp, so they update the cycle after a push or pop.
- Sticky flags clear only on reset.
- Reset asserted mid-operation aborts any pending request. The first post-reset edge acts normally.
- Latency: one cycle from request to new PC visible.

Optional Feature:
- Macro: PC_RAS_WRAP_EN.
- Defined: RAS is circular. A call while full overwrites the oldest entry and sp saturates at RAS_DEPTH; ras_ovf is still set. Returns then yield the newest RAS_DEPTH addresses.
- Not defined: discard-on-full behaviour as specified above.

Decomposition:
- Shared package pc_pkg:
  - default PC_W / OFF_W / RAS_DEPTH constants;
  - RESET_PC;
  - a request-priority enum (REQ_STALL, REQ_RET, REQ_CALL, REQ_JMP, REQ_INC, REQ_HOLD) used by the decoder and the testbench.
- One natural sub-module: ras_stack (storage, pointer, full/empty, overflow/underflow, wrap option).
- The top-level module keeps the priority mux and the PC register.

Test Plan:
- Reset then inc with in=0x01 for 3 cycles -> PC 0x0000, 0x0001, 0x0002, 0x0003. Idle cycle -> PC stays 0x0003.
- PC=0x0001, inc with in=0xFE -> PC=0xFFFF. Then inc with in=0x02 -> 0x0001 (wrap).
- From PC=0x0010, call with din=0x0100 -> PC=0x0100, ras_empty=0. ret -> PC=0x0011, ras_empty=1.
- 4 calls (RAS_DEPTH=4) then a 5th -> ras_full=1, ras_ovf=1, PC=5th din. 4 rets return the first 4 pushes in LIFO order.
  - With PC_RAS_WRAP_EN: rets return pushes 5,4,3,2.
- ret on empty RAS with PC=0x0042 -> PC=0x0042, ras_unf=1.
- Simultaneous stall+call+inc -> nothing changes. Simultaneous ret+wEnb -> ret wins.
- Drop reset low between edges during a call -> PC=RESET_PC immediately and RAS empty.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and request-priority decode for the fetch PC unit.
// Provides default widths, reset PC, and the req_e priority enum.
package pc_pkg;

    localparam int DEF_PC_W      = 16;
    localparam int DEF_OFF_W     = 8;
    localparam int DEF_RAS_DEPTH = 4;
    localparam int DEF_RESET_PC  = 0;

    typedef enum logic [2:0] {
        REQ_STALL,
        REQ_RET,
        REQ_CALL,
        REQ_JMP,
        REQ_INC,
        REQ_HOLD
    } req_e;

    // Highest-priority asserted request wins.
    function automatic req_e req_sel(
        input logic stall,
        input logic ret,
        input logic call,
        input logic jmp,
        input logic inc
    );
        if (stall)     return REQ_STALL;
        else if (ret)  return REQ_RET;
        else if (call) return REQ_CALL;
        else if (jmp)  return REQ_JMP;
        else if (inc)  return REQ_INC;
        else           return REQ_HOLD;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack: return-address stack with pointer, full/empty and sticky flags.
// Ports: clk, reset (async active-low), push/pop/wdata in; rdata, empty,
// full, ovf, unf out. Macro PC_RAS_WRAP_EN makes the stack circular.
module ras_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full,
    output logic         ovf,
    output logic         unf
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;

    logic [W-1:0]   mem [DEPTH];
    logic [SPW-1:0] sp;
    // wp tracks the next write slot; sp is the entry count.
    logic [IW-1:0]  wp;
    logic           wr;

`ifdef PC_RAS_WRAP_EN
    // Circular: a push when full overwrites the oldest slot.
    assign wr = push;
`else
    assign wr = push && !full;
`endif

    assign empty = (sp == '0);
    assign full  = (sp == SPW'(DEPTH));
    assign rdata = mem[wp - IW'(1)];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp  <= '0;
            wp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (wr) begin
                wp <= wp + IW'(1);
                if (!full)
                    sp <= sp + SPW'(1);
            end else if (pop && !empty) begin
                wp <= wp - IW'(1);
                sp <= sp - SPW'(1);
            end
            if (push && full)
                ovf <= 1'b1;
            if (pop && empty)
                unf <= 1'b1;
        end
    end

    // Contents need no reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (wr)
            mem[wp] <= wdata;
    end

endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: fetch PC with relative step, absolute jump and call/ret RAS.
// Ports: clk, reset (async active-low), stall, inc, in, wEnb, din, call,
// ret in; PC, ras_empty, ras_full, ras_ovf, ras_unf out.
// Macro PC_RAS_WRAP_EN selects a circular RAS (see ras_stack).
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int              PC_W      = DEF_PC_W,
    parameter int              OFF_W     = DEF_OFF_W,
    parameter int              RAS_DEPTH = DEF_RAS_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(DEF_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             inc,
    input  logic [OFF_W-1:0] in,
    input  logic             wEnb,
    input  logic [PC_W-1:0]  din,
    input  logic             call,
    input  logic             ret,
    output logic [PC_W-1:0]  PC,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf
);

    req_e            req;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] step;
    logic [PC_W-1:0] ret_pc;
    logic [PC_W-1:0] link;
    logic            push;
    logic            pop;

    assign req  = req_sel(stall, ret, call, wEnb, inc);
    assign step = PC_W'($signed(in));
    assign link = PC + PC_W'(1);
    assign push = (req == REQ_CALL);
    assign pop  = (req == REQ_RET);

    always_comb begin
        pc_nxt = PC;
        unique case (req)
            REQ_RET:  if (!ras_empty) pc_nxt = ret_pc;
            REQ_CALL: pc_nxt = din;
            REQ_JMP:  pc_nxt = din;
            REQ_INC:  pc_nxt = PC + step;
            default:  pc_nxt = PC;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            PC <= RESET_PC;
        else
            PC <= pc_nxt;
    end

    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (link),
        .rdata (ret_pc),
        .empty (ras_empty),
        .full  (ras_full),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed checks of step, jump, call/ret, RAS limits
// and async reset for pc_stack_unit with default parameters.
module tb_pc_stack_unit;
    import pc_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        inc;
    logic [7:0]  in;
    logic        wEnb;
    logic [15:0] din;
    logic        call;
    logic        ret;
    logic [15:0] PC;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        ras_unf;

    int n_chk  = 0;
    int n_fail = 0;

    pc_stack_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .inc       (inc),
        .in        (in),
        .wEnb      (wEnb),
        .din       (din),
        .call      (call),
        .ret       (ret),
        .PC        (PC),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input req_e r,
                         input logic [7:0] off,
                         input logic [15:0] d);
        stall = (r == REQ_STALL);
        ret   = (r == REQ_RET);
        call  = (r == REQ_CALL);
        wEnb  = (r == REQ_JMP);
        inc   = (r == REQ_INC);
        in    = off;
        din   = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_ret [4];

    initial begin
`ifdef PC_RAS_WRAP_EN
        exp_ret[0] = 16'h0501;
        exp_ret[1] = 16'h0401;
        exp_ret[2] = 16'h0301;
        exp_ret[3] = 16'h0201;
`else
        exp_ret[0] = 16'h0401;
        exp_ret[1] = 16'h0301;
        exp_ret[2] = 16'h0201;
        exp_ret[3] = 16'h0012;
`endif
        drive(REQ_HOLD, 8'h00, 16'h0000);
        reset = 1'b0;
        #12;
        reset = 1'b1;
        check("rst_pc", PC, 16'h0000);
        check("rst_empty", 16'(ras_empty), 16'd1);
        check("rst_full", 16'(ras_full), 16'd0);
        check("rst_ovf", 16'(ras_ovf), 16'd0);
        check("rst_unf", 16'(ras_unf), 16'd0);

        for (int i = 1; i <= 3; i++) begin
            drive(REQ_INC, 8'h01, 16'h0000);
            tick();
            check("inc1", PC, 16'(i));
        end
        drive(REQ_HOLD, 8'h00, 16'h0000);
        tick();
        check("idle_hold", PC, 16'h0003);

        drive(REQ_JMP, 8'h00, 16'h0001);
        tick();
        check("jmp", PC, 16'h0001);
        drive(REQ_INC, 8'hFE, 16'h0000);
        tick();
        check("inc_neg", PC, 16'hFFFF);
        drive(REQ_INC, 8'h02, 16'h0000);
        tick();
        check("inc_wrap", PC, 16'h0001);

        drive(REQ_JMP, 8'h00, 16'h0010);
        tick();
        drive(REQ_CALL, 8'h00, 16'h0100);
        tick();
        check("call_pc", PC, 16'h0100);
        check("call_nempty", 16'(ras_empty), 16'd0);
        drive(REQ_RET, 8'h00, 16'h0000);
        tick();
        check("ret_pc", PC, 16'h0011);
        check("ret_empty", 16'(ras_empty), 16'd1);

        for (int i = 0; i < 4; i++) begin
            drive(REQ_CALL, 8'h00, 16'((i + 2) * 256));
            tick();
        end
        check("call4_full", 16'(ras_full), 16'd1);
        check("call4_ovf", 16'(ras_ovf), 16'd0);
        drive(REQ_CALL, 8'h00, 16'h0600);
        tick();
        check("call5_pc", PC, 16'h0600);
        check("call5_full", 16'(ras_full), 16'd1);
        check("call5_ovf", 16'(ras_ovf), 16'd1);
        for (int i = 0; i < 4; i++) begin
            drive(REQ_RET, 8'h00, 16'h0000);
            tick();
            check($sformatf("lifo%0d", i), PC, exp_ret[i]);
        end
        check("lifo_empty", 16'(ras_empty), 16'd1);

        drive(REQ_JMP, 8'h00, 16'h0042);
        tick();
        drive(REQ_RET, 8'h00, 16'h0000);
        tick();
        check("unf_pc", PC, 16'h0042);
        check("unf_flag", 16'(ras_unf), 16'd1);

        drive(REQ_HOLD, 8'h01, 16'h0077);
        stall = 1'b1;
        call  = 1'b1;
        inc   = 1'b1;
        tick();
        check("stall_pc", PC, 16'h0042);
        check("stall_empty", 16'(ras_empty), 16'd1);

        drive(REQ_CALL, 8'h00, 16'h0080);
        tick();
        drive(REQ_RET, 8'h00, 16'h0099);
        wEnb = 1'b1;
        tick();
        check("ret_over_jmp", PC, 16'h0043);

        drive(REQ_CALL, 8'h00, 16'h0050);
        tick();
        check("pre_rst_nempty", 16'(ras_empty), 16'd0);
        drive(REQ_CALL, 8'h00, 16'h0123);
        #2;
        reset = 1'b0;
        #1;
        check("arst_pc", PC, 16'h0000);
        check("arst_empty", 16'(ras_empty), 16'd1);
        check("arst_ovf", 16'(ras_ovf), 16'd0);
        check("arst_unf", 16'(ras_unf), 16'd0);
        #1;
        reset = 1'b1;
        tick();
        check("post_rst_call", PC, 16'h0123);
        check("post_rst_nempty", 16'(ras_empty), 16'd0);
        drive(REQ_RET, 8'h00, 16'h0000);
        tick();
        check("post_rst_ret", PC, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
